// File: rtl/pp_adder_tree.sv
// Pipelined binary adder tree that sums WIDTH partial products into a 2*WIDTH-bit product.
// All stages advance together under a single enable, so a stalled output freezes the whole pipe.
module pp_add_node #(
    parameter int W2 = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [W2-1:0] a,
    input  logic [W2-1:0] b,
    output logic [W2-1:0] sum
);
    always_ff @(posedge clk) begin
        if (rst)     sum <= '0;
        else if (en) sum <= a + b;
    end
endmodule

module pp_adder_tree #(
    parameter int WIDTH  = 4,
    localparam int LEVELS = $clog2(WIDTH),
    localparam int W2     = 2 * WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tree_valid,
    input  logic [WIDTH*W2-1:0] tree_din,
    output logic                tree_ready,
    output logic                product_valid,
    output logic [W2-1:0]       product_dout,
    input  logic                product_ready
);
    // Nodes stored heap-like: level k starts at 2*WIDTH - 2*(WIDTH>>k); root is last.
    logic [W2-1:0]   node [0:2*WIDTH-2];
    logic [LEVELS:0] vld_pipe;
    logic            adv;

    assign adv         = ~vld_pipe[LEVELS] | product_ready;
    assign tree_ready  = adv;
    assign vld_pipe[0] = tree_valid;

    genvar i, k, j;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_pp
            assign node[i] = tree_din[i*W2 +: W2];
        end

        for (k = 1; k <= LEVELS; k++) begin : g_lvl
            localparam int OFF_IN  = 2*WIDTH - 2*(WIDTH >> (k-1));
            localparam int OFF_OUT = 2*WIDTH - 2*(WIDTH >> k);

            for (j = 0; j < (WIDTH >> k); j++) begin : g_node
                pp_add_node #(.W2(W2)) u_node (
                    .clk (clk),
                    .rst (rst),
                    .en  (adv),
                    .a   (node[OFF_IN + 2*j]),
                    .b   (node[OFF_IN + 2*j + 1]),
                    .sum (node[OFF_OUT + j])
                );
            end

            always_ff @(posedge clk) begin
                if (rst)      vld_pipe[k] <= 1'b0;
                else if (adv) vld_pipe[k] <= vld_pipe[k-1];
            end
        end
    endgenerate

    assign product_valid = vld_pipe[LEVELS];
    assign product_dout  = node[2*WIDTH-2];
endmodule

// File: doc/pp_adder_tree.md
PP_ADDER_TREE -- requirements
Module: pp_adder_tree

Interface
- REQ-001: Parameter WIDTH, default 4, operand width of the multiplier; legal values are powers of two, 2 to 32.
- REQ-002: Derived constant LEVELS = log2(WIDTH), the number of adder pipeline stages.
- REQ-003: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-004: rst  input  1  reset, synchronous and active-high.
- REQ-005: tree_valid  input  1  a partial-product set is present on tree_din.
- REQ-006: tree_din  input  WIDTH*2*WIDTH  packed partial products; pp[i] = tree_din[i*2*WIDTH +: 2*WIDTH], one per shift_unit row.
- REQ-007: tree_ready  output  1  the block accepts tree_din this cycle.
- REQ-008: product_valid  output  1  product_dout holds a result.
- REQ-009: product_dout  output  2*WIDTH  unsigned sum of all pp[i].
- REQ-010: product_ready  input  1  the consumer takes product_dout this cycle.

Function
- REQ-011: Binary adder tree: stage k (1..LEVELS) adds adjacent pairs of stage k-1 results and registers them; stage 0 is pp[0..WIDTH-1].
- REQ-012: Each stage has one valid bit, registered alongside its data; stage LEVELS data/valid drive product_dout/product_valid directly.
- REQ-013: Global advance enable adv = ~product_valid | product_ready; all stage registers (data and valid) load only when adv = 1.
- REQ-014: tree_ready = adv, combinational, no dependency on tree_valid.
- REQ-015: Accept = tree_valid & tree_ready; stage 1 valid loads tree_valid when adv = 1, so bubbles propagate as valid = 0.
- REQ-016: When adv = 0, every stage holds data and valid unchanged; tree_din is ignored.
- REQ-017: Latency: a set accepted at edge N yields product_valid = 1 after edge N+LEVELS-1 when no stall occurs (LEVELS register stages, first register at acceptance edge).
- REQ-018: Throughput: one set per cycle while product_ready = 1 or product_valid = 0.
- REQ-019: Bubbles are not compressed; a stall freezes the whole pipe including empty stages.
- REQ-020: All additions are 2*WIDTH bits wide, unsigned, result truncated modulo 2^(2*WIDTH); no carry-out port.
- REQ-021: For legal shift_unit inputs (WIDTH-bit times WIDTH-bit product) no truncation occurs.
- REQ-022: Stage data with valid = 0 holds whatever was computed from tree_din; consumers ignore product_dout while product_valid = 0.
- REQ-023: product_valid = 1 with product_ready = 0: product_dout stays stable until product_ready = 1.
- REQ-024: Simultaneous final-stage drain and new acceptance in the same cycle is legal and loses no data.
- REQ-025: WIDTH = 2 yields a single stage (LEVELS = 1), latency 1.

Reset
- REQ-026: rst = 1 at a rising edge clears all stage valid bits and all stage data to 0.
- REQ-027: During and after reset: product_valid = 0, product_dout = 0, tree_ready = 1.
- REQ-028: Reset mid-operation discards all in-flight sets; no result is produced for them.
- REQ-029: rst takes priority over adv and tree_valid in the same cycle.

Verification (WIDTH = 4, LEVELS = 2)
- REQ-030: Single set, product_ready = 1: pp = 0x03, 0x06, 0x00, 0x18, tree_valid for one cycle -> product_valid = 1 for exactly one cycle, 2 edges after acceptance, product_dout = 0x21.
- REQ-031: Maximum product: pp = 0x0F, 0x1E, 0x3C, 0x78 -> product_dout = 0xE1.
- REQ-032: Wrap: all pp = 0xFF -> product_dout = 0xFC (1020 mod 256).
- REQ-033: Back-to-back: 8 consecutive random legal sets, product_ready = 1 -> 8 consecutive valid results, in order, matching a reference sum.
- REQ-034: Backpressure: product_ready = 0 for 5 cycles with the pipe full -> tree_ready = 0, product_dout stable. Then product_ready = 1 -> all results delivered in order, none lost or duplicated.
- REQ-035: Reset mid-stream: rst = 1 for one cycle with 2 sets in flight -> next cycle product_valid = 0, product_dout = 0, tree_ready = 1, and no stale result appears afterwards.
